// File: rtl/mux_arb_pkg.sv
// Shared types for the 4:1 round-robin arbiter/sequencer.
// Latency: n/a (types only). Backpressure: n/a.
// Lock types are used only when MUX_ARB_PKT_LOCK_EN is defined.
package mux_arb_pkg;

    localparam int SEL_BITS = 2;
    localparam int NUM_REQ  = 1 << SEL_BITS;

    typedef logic [SEL_BITS-1:0] sel_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    function automatic sel_t sel_next(input sel_t s);
        return s + sel_t'(1);
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotate-priority picker: first valid requester at or after ptr wins.
// Latency: combinational. Backpressure: none, pure function of valid/ptr.
// Lowest rotation offset has highest priority; no valid means grant_valid=0.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [3:0] valid,
    input  logic [1:0] ptr,
    output logic       grant_valid,
    output logic [1:0] grant
);

    logic [1:0] idx;

    // Walk from the farthest offset down so the nearest valid one is kept last.
    always_comb begin
        grant_valid = 1'b0;
        grant       = ptr;
        idx         = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (valid[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

endmodule

// File: rtl/mux_arb_4to1.sv
// Round-robin 4:1 arbiter feeding one registered output stage; MUX_ARB_PKT_LOCK_EN adds packet lock.
// Latency: 1 cycle from input transfer to out_valid; one word per cycle when out_ready=1.
// Backpressure: inputs accepted only when the output register is empty or being drained.
module mux_arb_4to1
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int SEL_WIDTH = 2   // only 2 is supported
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           in_valid,
    input  logic [WIDTH-1:0]     in_data0,
    input  logic [WIDTH-1:0]     in_data1,
    input  logic [WIDTH-1:0]     in_data2,
    input  logic [WIDTH-1:0]     in_data3,
    input  logic [3:0]           in_last,
    output logic [3:0]           in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_WIDTH-1:0] out_sel,
    input  logic                 out_ready
);

    sel_t             ptr;
    logic             load_en;
    logic [3:0]       pick_valid;
    logic             grant_valid;
    sel_t             grant;
    logic             xfer;
    logic             ptr_adv;
    logic [WIDTH-1:0] sel_data;

    assign load_en = !out_valid || out_ready;

`ifdef MUX_ARB_PKT_LOCK_EN
    lock_state_t state_q, state_d;
    sel_t        lock_id_q, lock_id_d;

    // While locked only the owning requester may be picked; gaps grant nobody.
    always_comb begin
        pick_valid = in_valid;
        if (state_q == LOCKED) begin
            pick_valid = in_valid & (4'b0001 << lock_id_q);
        end
    end

    // Pointer moves only when a packet completes (single beat or closing beat).
    assign ptr_adv = in_last[grant];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        case (state_q)
            IDLE: begin
                if (xfer && !in_last[grant]) begin
                    state_d   = LOCKED;
                    lock_id_d = grant;
                end
            end
            LOCKED: begin
                if (xfer && in_last[grant]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
`else
    logic unused_last;

    assign pick_valid  = in_valid;
    assign ptr_adv     = 1'b1;
    assign unused_last = ^in_last;
`endif

    rr_pick4 u_pick (
        .valid       (pick_valid),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    assign xfer = load_en && grant_valid;

    always_comb begin
        in_ready = 4'b0000;
        if (xfer && !rst) begin
            in_ready = 4'b0001 << grant;
        end
    end

    always_comb begin
        case (grant)
            2'd0:    sel_data = in_data0;
            2'd1:    sel_data = in_data1;
            2'd2:    sel_data = in_data2;
            default: sel_data = in_data3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_sel   <= SEL_WIDTH'(grant);
                if (ptr_adv) begin
                    ptr <= sel_next(grant);
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_4to1.sv
// Randomized + directed bench for mux_arb_4to1 against a behavioural round-robin model.
// Honours MUX_ARB_PKT_LOCK_EN for the packet-lock model and directed lock sequence.
module tb_mux_arb_4to1;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [15:0] d0, d1, d2, d3;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    int vectors;
    int miscompares;

    // behavioural model state
    bit          m_ov;
    logic [15:0] m_od;
    int          m_os;
    int          m_ptr;
    bit          m_lock;
    int          m_lock_id;

    logic [3:0]  xfer_prev;
    int          pct_valid [4];
    int          pct_ready;
    int          pct_last;
    bit          track3;
    int          wait3;

    mux_arb_4to1 #(.WIDTH(16), .SEL_WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data0  (d0),
        .in_data1  (d1),
        .in_data2  (d2),
        .in_data3  (d3),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] data_of(input int i);
        case (i)
            0:       return d0;
            1:       return d1;
            2:       return d2;
            default: return d3;
        endcase
    endfunction

    function automatic void set_data(input int i, input logic [15:0] v);
        case (i)
            0:       d0 = v;
            1:       d1 = v;
            2:       d2 = v;
            default: d3 = v;
        endcase
    endfunction

    // Who would be served: lock owner only, else first valid scanning from the pointer.
    function automatic int mdl_pick(input logic [3:0] v);
`ifdef MUX_ARB_PKT_LOCK_EN
        if (m_lock) return v[m_lock_id] ? m_lock_id : -1;
`endif
        for (int k = 0; k < 4; k++) begin
            if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic void mdl_reset();
        m_ov      = 1'b0;
        m_od      = 16'h0;
        m_os      = 0;
        m_ptr     = 0;
        m_lock    = 1'b0;
        m_lock_id = 0;
        xfer_prev = 4'b0;
        wait3     = 0;
    endfunction

    // Inputs are already driven; check in_ready, advance model, clock, check outputs.
    task automatic one_cycle();
        int         g;
        bit         ld;
        logic [3:0] er;
        #1;
        g  = mdl_pick(in_valid);
        ld = !m_ov || out_ready;
        er = (ld && g >= 0) ? 4'(1 << g) : 4'b0;
        chk("in_ready", 32'(in_ready), 32'(er));
        if (track3 && in_ready != 4'b0 && in_valid[3]) begin
            if (in_ready[3]) wait3 = 0;
            else begin
                wait3++;
                chk("starve3", 32'(wait3 <= 3), 32'd1);
            end
        end
        xfer_prev = er;
        if (ld) begin
            if (g >= 0) begin
                m_ov = 1'b1;
                m_od = data_of(g);
                m_os = g;
`ifdef MUX_ARB_PKT_LOCK_EN
                if (in_last[g]) begin
                    m_lock = 1'b0;
                    m_ptr  = (g + 1) % 4;
                end else if (!m_lock) begin
                    m_lock    = 1'b1;
                    m_lock_id = g;
                end
`else
                m_ptr = (g + 1) % 4;
`endif
            end else begin
                m_ov = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("out_sel", 32'(out_sel), 32'(m_os));
    endtask

    // Requesters hold valid/data until served, then redraw.
    task automatic gen_random();
        for (int i = 0; i < 4; i++) begin
            if (!(in_valid[i] && !xfer_prev[i])) begin
                in_valid[i] = ($urandom_range(99) < pct_valid[i]);
                set_data(i, 16'($urandom));
                in_last[i] = ($urandom_range(99) < pct_last);
            end
        end
        out_ready = ($urandom_range(99) < pct_ready);
    endtask

    task automatic run_random(input int n);
        for (int c = 0; c < n; c++) begin
            gen_random();
            one_cycle();
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 4'b0;
        in_last   = 4'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        mdl_reset();
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        track3      = 1'b0;
        rst         = 1'b1;
        in_valid    = 4'b1111;
        in_last     = 4'b1111;
        d0 = 16'h0; d1 = 16'h0; d2 = 16'h0; d3 = 16'h0;
        out_ready   = 1'b1;
        mdl_reset();

        // reset state, with requesters already asserting valid
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_ptr", 32'(dut.ptr), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 4'b0010;
        d1       = 16'hA5A5;

        // single requester
        one_cycle();
        chk("single_data", 32'(out_data), 32'h0000A5A5);
        chk("single_sel", 32'(out_sel), 32'd1);
        chk("single_ptr", 32'(dut.ptr), 32'd2);

        // all four valid, fixed data, always ready: 0,1,2,3,0,...
        do_reset();
        in_valid = 4'b1111;
        d0 = 16'h1111; d1 = 16'h2222; d2 = 16'h3333; d3 = 16'h4444;
        for (int c = 0; c < 8; c++) begin
            one_cycle();
            chk("rr_order", 32'(out_sel), 32'(c % 4));
        end

        // backpressure for 3 cycles, then release
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            one_cycle();
            chk("bp_data_hold", 32'(out_data), 32'h00004444);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) one_cycle();

        // starvation: requester 3 always valid, 0 toggling, single-beat packets
        do_reset();
        pct_valid = '{50, 30, 30, 100};
        pct_ready = 70;
        pct_last  = 100;
        track3    = 1'b1;
        run_random(200);
        track3    = 1'b0;

        // general random traffic (packets of random length under the lock build)
        pct_valid = '{60, 40, 70, 50};
        pct_ready = 60;
        pct_last  = 40;
        run_random(600);

        // async reset mid-stream, between edges
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        one_cycle();
        one_cycle();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_ptr", 32'(dut.ptr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mdl_reset();
        in_valid = 4'b1010;
        one_cycle();
        chk("post_rst_sel", 32'(out_sel), 32'd1);

`ifdef MUX_ARB_PKT_LOCK_EN
        // requester 2 sends 3 beats while 0 and 1 wait; gap in the middle
        do_reset();
        in_valid = 4'b0100;
        in_last  = 4'b0011;
        d2 = 16'hB001;
        one_cycle();
        chk("lock_beat1", 32'(out_sel), 32'd2);
        in_valid = 4'b0011;
        d0 = 16'hC000; d1 = 16'hC001;
        one_cycle();
        chk("lock_gap", 32'(out_valid), 32'd0);
        in_valid = 4'b0111;
        d2 = 16'hB002;
        one_cycle();
        chk("lock_beat2", 32'(out_sel), 32'd2);
        in_last[2] = 1'b1;
        d2 = 16'hB003;
        one_cycle();
        chk("lock_beat3", 32'(out_sel), 32'd2);
        in_valid = 4'b0011;
        one_cycle();
        chk("lock_after", 32'(out_sel), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
